// File: rtl/nn_pipe_pkg.sv
// nn_pipe_pkg: shared types and constants for the NN pipeline feed path
package nn_pipe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam logic OUT_DATA_RST_BIT = 1'b0;
    typedef enum logic {IDLE, RUN} feed_state_t;
endpackage

// File: rtl/nn_feed_mem.sv
// nn_feed_mem: DEPTH x DATA_W buffer, one write port, registered read port
module nn_feed_mem
    import nn_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // The read register doubles as the output word register; it holds when re=0.
    always_ff @(posedge clk)
        if (rst) rdata <= {DATA_W{OUT_DATA_RST_BIT}};
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/nn_feed_ctrl.sv
// nn_feed_ctrl: buffers loaded words and issues them in order over valid/ready
module nn_feed_ctrl
    import nn_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              clear,
    input  logic              start,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic [ADDR_W:0]   issued_count
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    feed_state_t state, state_n;
    logic [ADDR_W:0] rd_ptr, rd_ptr_n, word_count_n, issued_count_n;
    logic idle, rd, hs, we, stall, out_valid_n, out_last_n, done_n;

    always_comb begin
        idle           = state == IDLE;
        hs             = out_valid & out_ready;
        stall          = out_valid & !out_ready;
        rd             = !idle & (rd_ptr < word_count) & !stall;
        load_ready     = idle & !start & !clear & (word_count < FULL);
        we             = load_valid & load_ready;
        state_n        = idle ? ((start & word_count != '0) ? RUN : IDLE)
                              : ((hs & out_last) ? IDLE : RUN);
        rd_ptr_n       = idle ? (start ? '0 : rd_ptr) : rd_ptr + {{ADDR_W{1'b0}}, rd};
        word_count_n   = !idle ? word_count
                       : clear ? '0 : word_count + {{ADDR_W{1'b0}}, we};
        issued_count_n = idle ? ((clear | start) ? '0 : issued_count)
                              : issued_count + {{ADDR_W{1'b0}}, hs};
        out_valid_n    = rd | stall;
        out_last_n     = rd ? (rd_ptr == word_count - 1'b1) : stall & out_last;
        done_n         = idle ? (start & word_count == '0) : (hs & out_last);
        busy           = !idle;
    end

    always_ff @(posedge clk)
        if (rst) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            word_count   <= '0;
            issued_count <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            rd_ptr       <= rd_ptr_n;
            word_count   <= word_count_n;
            issued_count <= issued_count_n;
            out_valid    <= out_valid_n;
            out_last     <= out_last_n;
            done         <= done_n;
        end

    nn_feed_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (word_count[ADDR_W-1:0]),
        .wdata (load_data),
        .re    (rd),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (out_data)
    );
endmodule

// File: tb/tb_nn_feed_ctrl.sv
// tb_nn_feed_ctrl: directed scenarios for the feed controller
module tb_nn_feed_ctrl;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_ready;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic [ADDR_W:0]   issued_count;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_w [3] = '{32'h0000084F, 32'h00000001, 32'h00000002};

    nn_feed_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .clear(clear), .start(start),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done),
        .word_count(word_count), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [DATA_W-1:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks += 8;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset out_last got %b want 0", out_last); end
        if (out_data !== 32'h0) begin errors++; $display("FAIL reset out_data got %h want 0", out_data); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
        if (word_count !== 9'd0) begin errors++; $display("FAIL reset word_count got %0d want 0", word_count); end
        if (issued_count !== 9'd0) begin errors++; $display("FAIL reset issued_count got %0d want 0", issued_count); end
        if (load_ready !== 1'b1) begin errors++; $display("FAIL reset load_ready got %b want 1", load_ready); end
    endtask

    task automatic test_basic;
        do_clear();
        for (int i = 0; i < 3; i++) load_word(exp_w[i]);
        checks++;
        if (word_count !== 9'd3) begin errors++; $display("FAIL basic word_count got %0d want 3", word_count); end
        out_ready = 1'b1;
        pulse_start();
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic busy_t1 got %b want 1", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic valid_t1 got %b want 0", out_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL basic valid[%0d] got %b want 1", i, out_valid); end
            if (out_data !== exp_w[i]) begin errors++; $display("FAIL basic data[%0d] got %h want %h", i, out_data, exp_w[i]); end
            if (out_last !== (i == 2)) begin errors++; $display("FAIL basic last[%0d] got %b want %b", i, out_last, i == 2); end
        end
        tick();
        checks += 4;
        if (done !== 1'b1) begin errors++; $display("FAIL basic done got %b want 1", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL basic busy_end got %b want 0", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic valid_end got %b want 0", out_valid); end
        if (issued_count !== 9'd3) begin errors++; $display("FAIL basic issued_count got %0d want 3", issued_count); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic done_width got %b want 0", done); end
    endtask

    task automatic test_replay;
        int k = 0;
        int dn = 0;
        out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid && out_ready) begin
                checks += 2;
                if (k > 2 || out_data !== exp_w[k]) begin errors++; $display("FAIL replay data[%0d] got %h", k, out_data); end
                if (out_last !== (k == 2)) begin errors++; $display("FAIL replay last[%0d] got %b want %b", k, out_last, k == 2); end
                k++;
            end
            if (done) dn++;
        end
        checks += 2;
        if (k !== 3) begin errors++; $display("FAIL replay words got %0d want 3", k); end
        if (dn !== 1) begin errors++; $display("FAIL replay done_pulses got %0d want 1", dn); end
    endtask

    task automatic test_backpressure;
        int pat [6] = '{1, 0, 0, 1, 0, 1};
        int k = 0;
        int dn = 0;
        int done_c = -1;
        logic stall_prev = 1'b0;
        logic [DATA_W-1:0] prev = '0;
        do_clear();
        for (int i = 0; i < 3; i++) load_word(exp_w[i]);
        pulse_start();
        for (int c = 0; c < 20; c++) begin
            out_ready = (c < 6) ? pat[c][0] : 1'b1;
            #1;
            if (out_valid) begin
                if (stall_prev) begin
                    checks++;
                    if (out_data !== prev) begin errors++; $display("FAIL bp hold c%0d got %h want %h", c, out_data, prev); end
                end
                if (out_ready) begin
                    checks += 2;
                    if (k > 2 || out_data !== exp_w[k]) begin errors++; $display("FAIL bp data[%0d] got %h", k, out_data); end
                    if (out_last !== (k == 2)) begin errors++; $display("FAIL bp last[%0d] got %b want %b", k, out_last, k == 2); end
                    k++;
                end
            end
            stall_prev = out_valid & !out_ready;
            prev = out_data;
            if (done) begin dn++; done_c = c; end
            tick();
        end
        checks += 4;
        if (k !== 3) begin errors++; $display("FAIL bp words got %0d want 3", k); end
        if (dn !== 1) begin errors++; $display("FAIL bp done_pulses got %0d want 1", dn); end
        if (done_c !== 7) begin errors++; $display("FAIL bp done_cycle got %0d want 7", done_c); end
        if (issued_count !== 9'd3) begin errors++; $display("FAIL bp issued_count got %0d want 3", issued_count); end
        out_ready = 1'b1;
    endtask

    task automatic test_ignore_in_run;
        logic seen = 1'b0;
        do_clear();
        for (int i = 0; i < 3; i++) load_word(exp_w[i]);
        out_ready = 1'b0;
        pulse_start();
        load_valid = 1'b1;
        load_data  = 32'hDEADBEEF;
        clear      = 1'b1;
        start      = 1'b1;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL run load_ready got %b want 0", load_ready); end
        tick();
        tick();
        checks += 4;
        if (word_count !== 9'd3) begin errors++; $display("FAIL run word_count got %0d want 3", word_count); end
        if (busy !== 1'b1) begin errors++; $display("FAIL run busy got %b want 1", busy); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL run valid got %b want 1", out_valid); end
        if (out_data !== exp_w[0]) begin errors++; $display("FAIL run data got %h want %h", out_data, exp_w[0]); end
        load_valid = 1'b0;
        clear      = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = done;
        end
        checks += 3;
        if (!seen) begin errors++; $display("FAIL run done_timeout got 0 want 1"); end
        if (issued_count !== 9'd3) begin errors++; $display("FAIL run issued_count got %0d want 3", issued_count); end
        if (word_count !== 9'd3) begin errors++; $display("FAIL run word_count_end got %0d want 3", word_count); end
    endtask

    task automatic test_empty;
        logic any = 1'b0;
        do_clear();
        pulse_start();
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL empty done got %b want 1", done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL empty busy got %b want 0", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL empty valid got %b want 0", out_valid); end
        for (int c = 0; c < 4; c++) begin
            tick();
            any |= out_valid | busy | done;
        end
        checks++;
        if (any !== 1'b0) begin errors++; $display("FAIL empty quiet got %b want 0", any); end
    endtask

    task automatic test_rst_mid;
        do_clear();
        for (int i = 0; i < 5; i++) load_word(32'h100 + i);
        out_ready = 1'b1;
        pulse_start();
        tick();
        tick();
        tick();
        checks++;
        if (issued_count !== 9'd2) begin errors++; $display("FAIL rstmid issued_before got %0d want 2", issued_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid valid got %b want 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy got %b want 0", busy); end
        if (word_count !== 9'd0) begin errors++; $display("FAIL rstmid word_count got %0d want 0", word_count); end
        if (issued_count !== 9'd0) begin errors++; $display("FAIL rstmid issued_count got %0d want 0", issued_count); end
        if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid data got %h want 0", out_data); end
    endtask

    task automatic test_full;
        int k = 0;
        logic seen = 1'b0;
        do_clear();
        for (int i = 0; i < DEPTH; i++) load_word(32'hA5000000 | i);
        checks++;
        if (word_count !== 9'd256) begin errors++; $display("FAIL full word_count got %0d want 256", word_count); end
        load_valid = 1'b1;
        load_data  = 32'hDEADBEEF;
        #1;
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL full load_ready got %b want 0", load_ready); end
        tick();
        load_valid = 1'b0;
        checks++;
        if (word_count !== 9'd256) begin errors++; $display("FAIL full word_count_after got %0d want 256", word_count); end
        out_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 300 && !seen; c++) begin
            tick();
            if (out_valid) begin
                checks += 2;
                if (out_data !== (32'hA5000000 | k)) begin errors++; $display("FAIL full data[%0d] got %h want %h", k, out_data, 32'hA5000000 | k); end
                if (out_last !== (k == DEPTH - 1)) begin errors++; $display("FAIL full last[%0d] got %b", k, out_last); end
                k++;
            end
            seen = done;
        end
        checks += 3;
        if (k !== DEPTH) begin errors++; $display("FAIL full words got %0d want %0d", k, DEPTH); end
        if (!seen) begin errors++; $display("FAIL full done_timeout got 0 want 1"); end
        if (issued_count !== 9'd256) begin errors++; $display("FAIL full issued_count got %0d want 256", issued_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_replay();
        test_backpressure();
        test_ignore_in_run();
        test_empty();
        test_rst_mid();
        test_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
